// File: rtl/mbd_pkg.sv
// Shared MinBD router definitions.
//
// Holds the flit geometry used by the deflection pipeline and its side
// buffering stages: flit width, number of channel slots, position of the
// valid bit, the flit type and small helpers for working on the packed
// channel bus.
package mbd_pkg;

  localparam int FLIT_W  = 11;
  localparam int NCH     = 4;
  localparam int VLD_BIT = FLIT_W - 1;

  typedef logic [FLIT_W-1:0] flit_t;

  // Extract slot idx from a packed channel bus (slot i at [i*FLIT_W +: FLIT_W]).
  // A shift keeps the select free of index-width concerns.
  function automatic flit_t slot_get(input logic [NCH*FLIT_W-1:0] bus,
                                     input int unsigned idx);
    return flit_t'(bus >> (idx * FLIT_W));
  endfunction

  function automatic logic flit_vld(input flit_t f);
    return f[VLD_BIT];
  endfunction

endpackage

// File: rtl/sb_fifo.sv
// Small circular flit FIFO.
//
// DEPTH entries (power of two, at least 2); read and write pointers wrap
// naturally modulo DEPTH. The head entry is presented combinationally on
// rdata whenever the FIFO is non-empty. A push and a pop in the same cycle
// are accepted at any occupancy, including full: the pop is taken first, so
// the freed entry absorbs the push and the count is unchanged.
//
// Ports:
//   clk, rst_n  rising-edge clock, asynchronous active-low reset
//   push, wdata write request and data
//   pop         remove head entry (ignored when empty)
//   rdata       head entry
//   count       occupancy, 0..DEPTH
//   full, empty occupancy flags derived from the count register
module sb_fifo
  import mbd_pkg::*;
#(
  parameter int W     = FLIT_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // Pop has priority for space: a full FIFO still accepts a push if it pops.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: entries are only ever read after being written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/sb_reinject.sv
// MinBD side-buffer reinjection stage.
//
// Sits directly downstream of side_buffer. Flits pulled out of the
// deflection pipeline arrive on sb_in and are held in a small FIFO. Each
// cycle the oldest held flit is placed into the lowest-index empty channel
// slot. If the FIFO stays non-empty while every slot is occupied for THRESH
// cycles, slot 0 is forcibly swapped with the FIFO head (starvation
// avoidance); the displaced slot-0 flit joins the FIFO tail. The registered
// channel bus feeds the permutation/deflection network.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   sb_in     flit from side_buffer; valid bit set = push request
//   ch_in     NCH channel slots, slot i at [i*FLIT_W +: FLIT_W]
//   ch_out    registered channel slots after reinjection/redirect
//   sb_full   FIFO full; side_buffer must not buffer while high
//   sb_count  FIFO occupancy
//   redirect  one-cycle pulse: a forced redirect happened last cycle
//   ovf_err   sticky: a valid sb_in flit arrived while full and was dropped
module sb_reinject
  import mbd_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int THRESH = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  flit_t                   sb_in,
  input  logic [NCH*FLIT_W-1:0]   ch_in,
  output logic [NCH*FLIT_W-1:0]   ch_out,
  output logic                    sb_full,
  output logic [$clog2(DEPTH):0]  sb_count,
  output logic                    redirect,
  output logic                    ovf_err
);

  localparam int SW = $clog2(THRESH + 1);
  localparam logic [SW-1:0] THRESH_C = SW'(THRESH);

  flit_t                 slot_in [NCH];
  logic [NCH-1:0]        empty_vec;
  logic [NCH-1:0]        sel_oh;
  logic [NCH-1:0]        take_head;
  logic [NCH*FLIT_W-1:0] ch_out_d, ch_out_q;

  flit_t                 fifo_head;
  flit_t                 fifo_wdata;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;

  logic                  sb_vld;
  logic                  all_full;
  logic                  reinject;
  logic                  redirect_fire;
  logic                  ovf_now;

  logic [SW-1:0]         starve_d, starve_q;
  logic                  redirect_d, redirect_q;
  logic                  ovf_err_d, ovf_err_q;

  // Slot unpacking and per-slot vacancy.
  for (genvar g = 0; g < NCH; g++) begin : g_slot
    assign slot_in[g]   = slot_get(ch_in, g);
    assign empty_vec[g] = ~flit_vld(slot_in[g]);
  end

  // Isolate the lowest set bit: lowest-index empty slot as a one-hot.
  assign sel_oh   = empty_vec & (~empty_vec + NCH'(1));
  assign all_full = ~|empty_vec;
  assign sb_vld   = flit_vld(sb_in);

  // Reinject and redirect are exclusive: one needs a hole, the other none.
  assign reinject      = ~fifo_empty & ~all_full;
  assign redirect_fire = (starve_q == THRESH_C) & all_full & ~fifo_empty & ~sb_vld;

  assign fifo_pop = reinject | redirect_fire;

  // On redirect sb_in is invalid, so the write port is free for slot 0.
  assign fifo_push  = redirect_fire | (sb_vld & (~fifo_full | fifo_pop));
  assign fifo_wdata = redirect_fire ? slot_in[0] : sb_in;
  assign ovf_now    = sb_vld & fifo_full & ~fifo_pop;

  always_comb begin
    take_head = '0;
    if (reinject) begin
      take_head = sel_oh;
    end else if (redirect_fire) begin
      take_head = NCH'(1);
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_out
    assign ch_out_d[g*FLIT_W +: FLIT_W] = take_head[g] ? fifo_head : slot_in[g];
  end

  // Starvation counter: only advances while flits wait behind a full pipe.
  // At THRESH with sb_in valid the redirect is deferred and the count holds.
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || reinject || redirect_fire) begin
      starve_d = '0;
    end else if (starve_q != THRESH_C) begin
      starve_d = starve_q + SW'(1);
    end
  end

  assign redirect_d = redirect_fire;
  assign ovf_err_d  = ovf_err_q | ovf_now;

  sb_fifo #(
    .W     (FLIT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .count (sb_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_out_q   <= '0;
      starve_q   <= '0;
      redirect_q <= 1'b0;
      ovf_err_q  <= 1'b0;
    end else begin
      ch_out_q   <= ch_out_d;
      starve_q   <= starve_d;
      redirect_q <= redirect_d;
      ovf_err_q  <= ovf_err_d;
    end
  end

  assign ch_out   = ch_out_q;
  assign sb_full  = fifo_full;
  assign redirect = redirect_q;
  assign ovf_err  = ovf_err_q;

endmodule

// File: doc/sb_reinject.md
Name: sb_reinject

Overview:
- MinBD router stage directly downstream of side_buffer.
- Accepts flits that side_buffer pulled out of the deflection pipeline and holds them in a small FIFO.
- Reinjects the oldest held flit into the first empty router channel slot.
- If no slot frees up for too long, forcibly redirects a channel flit into the FIFO and takes its slot (starvation avoidance). Output feeds the permutation/deflection network.

Parameters:
- FLIT_W, 11, flit width; bit FLIT_W-1 is the valid bit.
- NCH, 4, router pipeline channel slots.
- DEPTH, 4, FIFO entries (power of two).
- THRESH, 7, starvation cycles before a forced redirect.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- sb_in  in  FLIT_W  flit from side_buffer sbout; valid bit set = push request.
- ch_in  in  NCH*FLIT_W  channel slots; slot i at bits [i*FLIT_W +: FLIT_W].
- ch_out  out  NCH*FLIT_W  registered channel slots after reinjection/redirect.
- sb_full  out  1  FIFO count == DEPTH; side_buffer must not buffer while high.
- sb_count  out  log2(DEPTH)+1  FIFO occupancy.
- redirect  out  1  registered pulse: forced redirect occurred last cycle.
- ovf_err  out  1  sticky: sb_in valid arrived while full.

Behaviour:
- Reset (async on rst_n low, any cycle, mid-operation included): ch_out=0, FIFO emptied (count 0, pointers 0), starve_cnt=0, redirect=0, ovf_err=0, sb_full=0. FIFO contents are discarded.
- Latency: ch_in to ch_out is exactly 1 cycle. Slots not modified pass unchanged, including invalid slots, bit for bit.
- FIFO: circular, rd/wr pointers wrap modulo DEPTH. Push and pop in the same cycle are allowed at any occupancy, including full: the pop happens first, so count is unchanged.
- Push: sb_in valid and (count<DEPTH or pop this cycle) -> write sb_in.
- Overflow: sb_in valid, full, and no pop -> flit dropped, ovf_err set. ovf_err clears only on reset.
- Reinject: FIFO non-empty and a slot has ch_in valid=0 -> the lowest-index empty slot gets the FIFO head; pop. At most one reinject per cycle.
- starve_cnt:
  - FIFO empty or a reinject occurs -> 0.
  - Otherwise (non-empty, all slots full) -> +1, saturating at THRESH.
- Forced redirect fires when all of the following hold:
  - starve_cnt==THRESH;
  - all NCH slots valid;
  - FIFO non-empty;
  - sb_in invalid this cycle.
- Redirect action: slot 0 gets the FIFO head (pop). The original slot 0 flit is pushed into the FIFO in the same cycle, so count is unchanged. starve_cnt resets to 0 and redirect is asserted next cycle.
- If sb_in is valid at THRESH, redirect is deferred: starve_cnt holds at THRESH and the push proceeds normally.
- Only one of reinject/redirect per cycle. They are mutually exclusive by construction: redirect requires all slots full, reinject requires an empty slot.
- sb_full and sb_count are registered and reflect post-update state.

Decomposition:
- Shared package mbd_pkg:
  - FLIT_W, NCH, valid-bit index constant;
  - flit_t typedef (packed FLIT_W);
  - slot-extract helper function.
- One sub-module: sb_fifo (DEPTH-entry circular FIFO with push/pop/count/full/empty). It is reusable by side_buffer's own holding logic.
- Slot select, starvation counter and output register stay in sb_reinject.

Test Plan:
- Reset mid-stream: FIFO holds 3 flits, drop rst_n asynchronously between edges -> ch_out=0, sb_count=0, sb_full=0, ovf_err=0 immediately; after release, ch_in passes through with 1-cycle latency.
- Simple reinject: push sb_in=11'b10000110101. Next cycle ch_in slots = {valid, invalid, valid, valid} (slot0..3) -> one cycle later slot1 = 11'b10000110101, others unchanged, sb_count=0.
- Lowest-index selection: FIFO holds A then B; slots 2 and 3 empty -> slot2 gets A (FIFO order), B remains, count=1. Next cycle slot 2 empty again -> B reinjected.
- Full/overflow: push 4 flits with all slots full -> sb_full=1. A 5th push with no pop -> dropped, ovf_err=1 sticky. A push plus a simultaneous pop while full -> accepted, count stays 4.
- Starvation redirect: one flit X in FIFO, all 4 slots valid for 8 cycles, sb_in invalid -> on the cycle starve_cnt=7, slot0 becomes X, old slot0 flit enters FIFO, redirect pulses one cycle, count stays 1, starve_cnt=0.
- Redirect deferral: same as above but sb_in valid at THRESH -> no redirect that cycle, count increments to 2. Redirect fires on the first following cycle with sb_in invalid.
